// File: rtl/lstm_pkg.sv
// Shared types, fixed-point helpers and tanh table generator for the LSTM cell update stage.
// Latency: n/a (package).
// Backpressure: n/a (package).
// Contents: DWIDTH/FRAC/N_HIDDEN/LUT_SHIFT, fix_t, sat_mul, sat_add, tanh_entry.
package lstm_pkg;
    localparam int DWIDTH    = 16;
    localparam int FRAC      = 8;
    localparam int N_HIDDEN  = 64;
    localparam int LUT_SHIFT = 3;
    localparam int LUT_DEPTH = 256;

    typedef logic signed [DWIDTH-1:0]   fix_t;
    typedef logic signed [2*DWIDTH-1:0] wide_t;

    localparam fix_t FIX_MAX = {1'b0, {(DWIDTH-1){1'b1}}};
    localparam fix_t FIX_MIN = {1'b1, {(DWIDTH-1){1'b0}}};

    function automatic fix_t sat(input wide_t v);
        if (v > wide_t'(FIX_MAX)) return FIX_MAX;
        if (v < wide_t'(FIX_MIN)) return FIX_MIN;
        return fix_t'(v);
    endfunction

    // Full-width product, arithmetic (floor) shift back to Q format, then clamp.
    function automatic fix_t sat_mul(input fix_t a, input fix_t b);
        wide_t p;
        p = wide_t'(a) * wide_t'(b);
        return sat(p >>> FRAC);
    endfunction

    function automatic fix_t sat_add(input fix_t a, input fix_t b);
        return sat(wide_t'(a) + wide_t'(b));
    endfunction

    // Taylor series for e^y, y >= 0; only evaluated when building the table.
    function automatic real exp_pos(input real y);
        real term;
        real sum;
        term = 1.0;
        sum  = 1.0;
        for (int n = 1; n < 60; n++) begin
            term = term * y / real'(n);
            sum  = sum + term;
        end
        return sum;
    endfunction

    // Table entry k = round(2^FRAC * tanh((k-128) * 2^LUT_SHIFT / 2^FRAC)).
    function automatic fix_t tanh_entry(input int k);
        real x;
        real e2;
        real t;
        real v;
        x  = real'((k - LUT_DEPTH/2) * (1 << LUT_SHIFT)) / real'(1 << FRAC);
        e2 = (x >= 0.0) ? exp_pos(2.0 * x) : 1.0 / exp_pos(-2.0 * x);
        t  = (e2 - 1.0) / (e2 + 1.0);
        v  = t * real'(1 << FRAC);
        if (v >= 0.0) return fix_t'($rtoi(v + 0.5));
        return fix_t'(-$rtoi(0.5 - v));
    endfunction
endpackage

// File: rtl/lstm_cell_update_if.sv
// Gate-tuple input stream and h/c result stream of the LSTM cell update stage.
// Latency: n/a (wiring only).
// Backpressure: valid/ready on both streams; slave = the stage, master = producer/consumer side.
interface lstm_cell_update_if #(
    parameter int N_HIDDEN = lstm_pkg::N_HIDDEN
);
    import lstm_pkg::*;
    localparam int IW = $clog2(N_HIDDEN);

    logic          in_valid;
    logic          in_ready;
    logic          in_first;
    fix_t          in_i;
    fix_t          in_f;
    fix_t          in_g;
    fix_t          in_o;
    logic          out_valid;
    logic          out_ready;
    fix_t          out_h;
    fix_t          out_c;
    logic [IW-1:0] out_idx;
    logic          out_last;

    modport master (
        output in_valid, in_first, in_i, in_f, in_g, in_o, out_ready,
        input  in_ready, out_valid, out_h, out_c, out_idx, out_last
    );

    modport slave (
        input  in_valid, in_first, in_i, in_f, in_g, in_o, out_ready,
        output in_ready, out_valid, out_h, out_c, out_idx, out_last
    );
endinterface

// File: rtl/tanh_lut.sv
// tanh lookup: clamps c to the table range, indexes a 256-entry ROM, registers the result.
// Latency: 1 cycle (registered on i_en).
// Backpressure: holds its output while i_en is low.
// Ports: clk, xrst (async active-low), i_en, i_c (signed c), o_tanh (signed tanh(c)).
module tanh_lut
    import lstm_pkg::*;
(
    input  logic clk,
    input  logic xrst,
    input  logic i_en,
    input  fix_t i_c,
    output fix_t o_tanh
);
    localparam int   IW   = $clog2(LUT_DEPTH);
    localparam fix_t C_LO = fix_t'(-((LUT_DEPTH/2) << LUT_SHIFT));
    localparam fix_t C_HI = fix_t'(((LUT_DEPTH/2) << LUT_SHIFT) - 1);

    fix_t          w_rom [LUT_DEPTH];
    fix_t          w_clamp;
    fix_t          w_shift;
    logic [IW-1:0] w_idx;
    fix_t          r_tanh;

    for (genvar k = 0; k < LUT_DEPTH; k++) begin : g_rom
        assign w_rom[k] = tanh_entry(k);
    end

    always_comb begin
        w_clamp = i_c;
        if (i_c < C_LO)
            w_clamp = C_LO;
        else if (i_c > C_HI)
            w_clamp = C_HI;
        w_shift = w_clamp >>> LUT_SHIFT;
        // After the clamp the shifted value is in [-128,127], so +128 fits the index exactly.
        w_idx   = IW'(w_shift + fix_t'(LUT_DEPTH/2));
    end

    always_ff @(posedge clk or negedge xrst) begin
        if (!xrst)
            r_tanh <= '0;
        else if (i_en)
            r_tanh <= w_rom[w_idx];
    end

    assign o_tanh = r_tanh;
endmodule

// File: rtl/lstm_cell_update.sv
// LSTM elementwise update: c_t = f*c_{t-1} + i*g, h_t = o*tanh(c_t), c_{t-1} kept in local memory.
// Latency: 4 cycles accept-to-out_valid, 1 element/cycle.
// Backpressure: single global enable; out_valid & ~out_ready freezes every stage and drops in_ready.
// Ports: clk, xrst (async active-low), clear (sync flush + counter zero), io (slave: gate stream in, h/c stream out).
module lstm_cell_update #(
    parameter int N_HIDDEN = lstm_pkg::N_HIDDEN   // must be >= 4: cmem write lands before the next read of the same index
) (
    input  logic                clk,
    input  logic                xrst,
    input  logic                clear,
    lstm_cell_update_if.slave   io
);
    import lstm_pkg::*;

    localparam int IW = $clog2(N_HIDDEN);
    typedef logic [IW-1:0] idx_t;
    localparam idx_t IDX_LAST = idx_t'(N_HIDDEN - 1);

    logic w_en;
    logic w_acc;
    fix_t w_cprev;
    fix_t w_c;
    fix_t w_tanh;

    idx_t r_cnt;
    fix_t r_cmem [N_HIDDEN];

    logic r_s1_vld;
    fix_t r_s1_i, r_s1_f, r_s1_g, r_s1_o, r_s1_cp;
    idx_t r_s1_idx;

    logic r_s2_vld;
    fix_t r_s2_p1, r_s2_p2, r_s2_o;
    idx_t r_s2_idx;

    logic r_s3_vld;
    fix_t r_s3_c, r_s3_o;
    idx_t r_s3_idx;

    logic r_out_vld;
    logic r_out_last;
    fix_t r_out_h, r_out_c;
    idx_t r_out_idx;

    assign w_en    = io.out_ready | ~r_out_vld;
    assign w_acc   = io.in_valid & w_en & ~clear;
    assign w_cprev = io.in_first ? '0 : r_cmem[r_cnt];
    assign w_c     = sat_add(r_s2_p1, r_s2_p2);

    // Control: element counter and stage valids; clear flushes everything in flight.
    always_ff @(posedge clk or negedge xrst) begin
        if (!xrst) begin
            r_cnt     <= '0;
            r_s1_vld  <= 1'b0;
            r_s2_vld  <= 1'b0;
            r_s3_vld  <= 1'b0;
            r_out_vld <= 1'b0;
        end else if (clear) begin
            r_cnt     <= '0;
            r_s1_vld  <= 1'b0;
            r_s2_vld  <= 1'b0;
            r_s3_vld  <= 1'b0;
            r_out_vld <= 1'b0;
        end else begin
            if (w_acc)
                r_cnt <= (r_cnt == IDX_LAST) ? '0 : r_cnt + idx_t'(1);
            if (w_en) begin
                r_s1_vld  <= io.in_valid;
                r_s2_vld  <= r_s1_vld;
                r_s3_vld  <= r_s2_vld;
                r_out_vld <= r_s3_vld;
            end
        end
    end

    // Datapath: bubbles carry don't-care data; only the valids matter.
    always_ff @(posedge clk or negedge xrst) begin
        if (!xrst) begin
            r_s1_i     <= '0;
            r_s1_f     <= '0;
            r_s1_g     <= '0;
            r_s1_o     <= '0;
            r_s1_cp    <= '0;
            r_s1_idx   <= '0;
            r_s2_p1    <= '0;
            r_s2_p2    <= '0;
            r_s2_o     <= '0;
            r_s2_idx   <= '0;
            r_s3_c     <= '0;
            r_s3_o     <= '0;
            r_s3_idx   <= '0;
            r_out_h    <= '0;
            r_out_c    <= '0;
            r_out_idx  <= '0;
            r_out_last <= 1'b0;
        end else if (w_en) begin
            r_s1_i     <= io.in_i;
            r_s1_f     <= io.in_f;
            r_s1_g     <= io.in_g;
            r_s1_o     <= io.in_o;
            r_s1_cp    <= w_cprev;
            r_s1_idx   <= r_cnt;
            r_s2_p1    <= sat_mul(r_s1_f, r_s1_cp);
            r_s2_p2    <= sat_mul(r_s1_i, r_s1_g);
            r_s2_o     <= r_s1_o;
            r_s2_idx   <= r_s1_idx;
            r_s3_c     <= w_c;
            r_s3_o     <= r_s2_o;
            r_s3_idx   <= r_s2_idx;
            r_out_c    <= r_s3_c;
            r_out_h    <= sat_mul(r_s3_o, w_tanh);
            r_out_idx  <= r_s3_idx;
            r_out_last <= (r_s3_idx == IDX_LAST);
        end
    end

    // c_t write-back in stage 3; a flushed element must not corrupt the stored state.
    always_ff @(posedge clk) begin
        if (w_en && r_s2_vld && !clear)
            r_cmem[r_s2_idx] <= w_c;
    end

    // tanh is looked up from the combinational c_t so its registered value lines up with r_s3_c.
    tanh_lut u_tanh (
        .clk    (clk),
        .xrst   (xrst),
        .i_en   (w_en),
        .i_c    (w_c),
        .o_tanh (w_tanh)
    );

    assign io.in_ready  = w_en;
    assign io.out_valid = r_out_vld;
    assign io.out_h     = r_out_h;
    assign io.out_c     = r_out_c;
    assign io.out_idx   = r_out_idx;
    assign io.out_last  = r_out_last;
endmodule

// File: tb/tb_lstm_cell_update.sv
// Directed bench for lstm_cell_update with N_HIDDEN=4 and hand-computed expectations.
// Latency: checks 4-cycle accept-to-output.
// Backpressure: exercises out_ready stalls, clear flush and mid-stream async reset.
module tb_lstm_cell_update;
    import lstm_pkg::*;

    localparam int NH = 4;

    logic clk  = 1'b0;
    logic xrst = 1'b1;
    logic clear = 1'b0;

    int total = 0;
    int bad   = 0;
    int exp_cnt = 0;

    lstm_cell_update_if #(.N_HIDDEN(NH)) io ();

    lstm_cell_update #(.N_HIDDEN(NH)) dut (
        .clk   (clk),
        .xrst  (xrst),
        .clear (clear),
        .io    (io)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic signed [31:0] obs, input logic signed [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // Push one tuple into an idle pipeline and check the single result it produces.
    task automatic send_one(input int i, input int f, input int g, input int o, input logic first,
                            input int exp_c, input int exp_h, input int exp_idx, input string tag);
        int lat;
        @(negedge clk);
        io.in_i      = fix_t'(i);
        io.in_f      = fix_t'(f);
        io.in_g      = fix_t'(g);
        io.in_o      = fix_t'(o);
        io.in_first  = first;
        io.in_valid  = 1'b1;
        io.out_ready = 1'b1;
        @(negedge clk);
        io.in_valid = 1'b0;
        lat = 1;
        while (!io.out_valid && lat < 20) begin
            @(negedge clk);
            lat++;
        end
        check({tag, ".lat"},  lat, 4);
        check({tag, ".c"},    32'(io.out_c), exp_c);
        check({tag, ".h"},    32'(io.out_h), exp_h);
        check({tag, ".idx"},  32'(io.out_idx), exp_idx);
        check({tag, ".last"}, 32'(io.out_last), 32'(exp_idx == NH - 1));
    endtask

    initial begin
        int sent;
        int got;
        int n_out;
        int ec;
        int eh;
        logic prev_stall;
        fix_t hold_c;
        logic [$clog2(NH)-1:0] hold_idx;

        io.in_valid  = 1'b0;
        io.in_first  = 1'b0;
        io.in_i      = '0;
        io.in_f      = '0;
        io.in_g      = '0;
        io.in_o      = '0;
        io.out_ready = 1'b0;

        // Reset state
        #1 xrst = 1'b0;
        #1;
        check("rst.valid", 32'(io.out_valid), 0);
        check("rst.h",     32'(io.out_h), 0);
        check("rst.c",     32'(io.out_c), 0);
        check("rst.idx",   32'(io.out_idx), 0);
        check("rst.last",  32'(io.out_last), 0);
        @(negedge clk);
        @(negedge clk);
        xrst = 1'b1;
        #1;
        check("rst.in_ready", 32'(io.in_ready), 1);

        // Basic tuple, then rest of timestep 1
        send_one(256, 128, 128, 256, 1'b1, 128, 118, 0, "basic");
        for (int k = 1; k < NH; k++)
            send_one(256, 128, 128, 256, 1'b1, 128, 118, k, "ts1");
        // Timestep 2 uses stored c_{t-1}=128
        for (int k = 0; k < NH; k++)
            send_one(256, 128, 128, 256, 1'b0, 192, 163, k, "ts2");

        // Negative values
        send_one(256, 0, -256, 256, 1'b1, -256, -195, 0, "neg");
        exp_cnt = 1;

        // Saturation: c grows 256 per timestep, clamps at 32767
        for (int t = 1; t <= 130; t++) begin
            ec = (t >= 128) ? 32767 : 256 * t;
            eh = (t == 1) ? 195 : (t == 2) ? 247 : (t == 3) ? 255 : 256;
            for (int e = 0; e < NH; e++) begin
                send_one(256, 256, 256, 256, (t == 1), ec, eh, exp_cnt, "sat");
                exp_cnt = (exp_cnt + 1) % NH;
            end
        end

        // Backpressure with out_ready pattern 1,0,0,1
        sent = 0;
        got = 0;
        prev_stall = 1'b0;
        hold_c = '0;
        hold_idx = '0;
        io.in_i = fix_t'(256);
        io.in_f = fix_t'(0);
        io.in_o = fix_t'(256);
        io.in_first = 1'b1;
        for (int cyc = 0; cyc < 200 && got < 8; cyc++) begin
            @(negedge clk);
            if (prev_stall) begin
                check("bp.hold_v",   32'(io.out_valid), 1);
                check("bp.hold_c",   32'(io.out_c), 32'(hold_c));
                check("bp.hold_idx", 32'(io.out_idx), 32'(hold_idx));
            end
            io.in_valid  = (sent < 8);
            io.in_g      = fix_t'(16 * (sent + 1));
            io.out_ready = (cyc % 4 == 0) || (cyc % 4 == 3);
            #1;
            if (io.out_valid && io.out_ready) begin
                check("bp.c",   32'(io.out_c), 16 * (got + 1));
                check("bp.idx", 32'(io.out_idx), (exp_cnt + got) % NH);
                got++;
            end
            if (io.in_valid && io.in_ready)
                sent++;
            prev_stall = io.out_valid && !io.out_ready;
            hold_c     = io.out_c;
            hold_idx   = io.out_idx;
        end
        @(negedge clk);
        io.in_valid  = 1'b0;
        io.out_ready = 1'b1;
        check("bp.sent", sent, 8);
        check("bp.got",  got, 8);
        n_out = 0;
        for (int k = 0; k < 6; k++) begin
            @(negedge clk);
            if (io.out_valid) n_out++;
        end
        check("bp.no_dup", n_out, 0);
        exp_cnt = (exp_cnt + 8) % NH;

        // Clear with two elements in flight, in_valid held high through the clear cycle
        if ((exp_cnt + 2) % NH == 0) begin
            send_one(256, 0, 128, 256, 1'b1, 128, 118, exp_cnt, "pad");
            exp_cnt = (exp_cnt + 1) % NH;
        end
        @(negedge clk);
        io.in_i = fix_t'(256);
        io.in_f = fix_t'(0);
        io.in_g = fix_t'(512);
        io.in_o = fix_t'(256);
        io.in_first  = 1'b1;
        io.in_valid  = 1'b1;
        io.out_ready = 1'b1;
        @(negedge clk);
        @(negedge clk);
        clear = 1'b1;
        @(negedge clk);
        clear = 1'b0;
        io.in_valid = 1'b0;
        check("clr.valid_next", 32'(io.out_valid), 0);
        n_out = 0;
        for (int k = 0; k < 8; k++) begin
            @(negedge clk);
            if (io.out_valid) n_out++;
        end
        check("clr.no_out", n_out, 0);
        send_one(256, 0, 128, 256, 1'b1, 128, 118, 0, "clr.next");

        // Async reset mid-stream
        @(negedge clk);
        io.in_i = fix_t'(256);
        io.in_f = fix_t'(0);
        io.in_g = fix_t'(256);
        io.in_o = fix_t'(256);
        io.in_first  = 1'b1;
        io.in_valid  = 1'b1;
        io.out_ready = 1'b1;
        repeat (4) @(negedge clk);
        io.in_valid = 1'b0;
        check("arst.pre_valid", 32'(io.out_valid), 1);
        #2 xrst = 1'b0;
        #1;
        check("arst.valid", 32'(io.out_valid), 0);
        check("arst.h",     32'(io.out_h), 0);
        check("arst.c",     32'(io.out_c), 0);
        check("arst.idx",   32'(io.out_idx), 0);
        check("arst.last",  32'(io.out_last), 0);
        @(negedge clk);
        xrst = 1'b1;
        #1;
        check("arst.in_ready", 32'(io.in_ready), 1);
        send_one(256, 0, -128, 256, 1'b1, -128, -118, 0, "arst.next");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/lstm_cell_update.md
Name: lstm_cell_update

Overview:
- Elementwise LSTM cell-state and hidden-state update stage, directly downstream of the gate-activation output of `top`.
- Consumes activated gates (i, f, g, o) one hidden element per handshake and keeps c_{t-1} in local memory.
- Computes c_t = f*c_{t-1} + i*g and h_t = o*tanh(c_t), then streams h_t/c_t to the next-timestep feedback path.
- All values are signed fixed-point Q(DWIDTH-FRAC).FRAC.

Parameters:
- DWIDTH, 16: data width of every gate, c and h value.
- FRAC, 8: fractional bits (1.0 = 256).
- N_HIDDEN, 64: hidden elements per timestep; must be >= 4.
- LUT_SHIFT, 3: right shift applied to the clamped c to form the tanh LUT index.

Ports:
- clk  in  1  system clock
- xrst  in  1  asynchronous active-low reset
- clear  in  1  synchronous: zero element counter, drop all in-flight data (memory untouched)
- in_valid  in  1  gate tuple valid
- in_ready  out  1  stage can accept
- in_first  in  1  first timestep of sequence: treat c_{t-1} as 0
- in_i, in_f, in_g, in_o  in  DWIDTH each  activated gates, signed
- out_valid  out  1  result valid
- out_ready  in  1  consumer accepts
- out_h  out  DWIDTH  h_t, signed
- out_c  out  DWIDTH  c_t, signed
- out_idx  out  clog2(N_HIDDEN)  element index of this result
- out_last  out  1  out_idx == N_HIDDEN-1

Behaviour:
- Reset (xrst=0, async): out_valid=0, out_h=0, out_c=0, out_idx=0, out_last=0, element counter=0, all stage valids=0. in_ready=1 after reset release.
- Pipeline: 4 stages, global enable en = out_ready | ~out_valid. All stages advance together on en; bubbles propagate as invalid.
- in_ready = en. A transfer occurs on in_valid & in_ready.
- Stage 1 (accept): read cmem[cnt] (0 if in_first), register i, f, g, o and idx. cnt advances on each transfer and wraps N_HIDDEN-1 -> 0.
- Stage 2: p1 = sat((f*c_prev) >>> FRAC), p2 = sat((i*g) >>> FRAC). Full 2*DWIDTH products, arithmetic shift (floor).
- Stage 3: c_t = sat(p1 + p2), written to cmem[idx] in this stage.
- Stage 4: tanh lookup, then h = sat((o*tanh) >>> FRAC). Outputs are registered here.
- sat() clamps to [-2^(DWIDTH-1), 2^(DWIDTH-1)-1].
- Latency: 4 cycles from accept to out_valid when out_ready stays 1. Throughput: 1 element per cycle.
- Backpressure: with out_valid=1 and out_ready=0, all stages hold, in_ready=0, and outputs stay stable.
- Hazard: cmem[k] is written in stage 3, at most 2 cycles after accept. The next read of index k is N_HIDDEN >= 4 accepts later, so no forwarding is needed. N_HIDDEN < 4 is illegal.
- tanh LUT: 256 entries. Index = (clamp(c, -128<<LUT_SHIFT, (128<<LUT_SHIFT)-1) >>> LUT_SHIFT) + 128. Entry k = round(2^FRAC * tanh((k-128)*2^LUT_SHIFT / 2^FRAC)), stored DWIDTH signed.
- clear and in_valid in the same cycle: clear wins and the input is not accepted. The cycle after clear has cnt=0 and out_valid=0.
- Async reset mid-operation discards in-flight data. cmem content is undefined after reset; the first timestep after reset must assert in_first.
- cmem: N_HIDDEN x DWIDTH, 1 read + 1 write port, no reset.

Decomposition:
- Package lstm_pkg holds DWIDTH, FRAC, N_HIDDEN, LUT_SHIFT, the typedef fix_t (signed [DWIDTH-1:0]), the sat_mul and sat_add functions, and the tanh LUT init function.
- Sub-module tanh_lut: combinational index clamp plus registered ROM read, used in stage 4.

Test Plan:
- Basic: in_first=1, i=256, f=128, g=128, o=256 at idx0 -> 4 cycles later out_c=128, out_h=118, out_idx=0.
- Recurrence: N_HIDDEN=4. Timestep 1 with in_first=1 and the basic tuple on all 4 elements, then timestep 2 with the same gates and in_first=0 -> each idx gives out_c=192, out_h=163; out_last=1 on idx3 only.
- Saturation/clip: f=i=g=o=256, in_first=0, repeated over many timesteps -> c grows by 256 per timestep and saturates at 32767. out_h=256 once c>=1023; no wrap to negative.
- Negative values: in_first=1, i=256, g=-256, f=0, o=256 -> out_c=-256, out_h=round(-256*tanh(1.0))=-195.
- Backpressure: stream 8 elements with out_ready toggled 1,0,0,1,... -> no loss or duplication; outputs stable while out_ready=0; in order idx0..7 mod N_HIDDEN.
- Clear/reset: after 2 in-flight accepts, assert clear -> no output appears and the next accept uses idx0. Assert xrst mid-stream -> out_valid drops immediately and all outputs are 0.
